// File: rtl/commutation_pkg.sv
// Shared constants and types for the commutation path: cycle length,
// velocity type and the angle generator's state encoding.
package commutation_pkg;

    localparam int CYCLE_LENGTH = 1170;
    localparam int VEL_WIDTH    = 16;

    typedef logic signed [VEL_WIDTH-1:0] velocity_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAMP     = 2'd1,
        CRUISE   = 2'd2,
        STOPPING = 2'd3
    } state_t;

    // New targets are refused only while the motor is being brought to rest.
    function automatic logic accepts_command(input state_t s);
        return s != STOPPING;
    endfunction

endpackage

// File: rtl/update_tick_generator.sv
// Free-running divider producing a one-cycle tick every DIVIDER clocks,
// on the last count of each period.
module update_tick_generator #(
    parameter int DIVIDER = 1024
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/commutation_angle_generator.sv
// Integrates a slew-limited signed velocity into the electrical cycle
// position consumed by the commutation stage.
module commutation_angle_generator #(
    parameter int CYCLE_LENGTH = commutation_pkg::CYCLE_LENGTH,
    parameter int TICK_DIVIDER = 1024,
    parameter int VEL_WIDTH    = 16,
    parameter int FRAC_BITS    = 8,
    parameter int ACCEL_STEP   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic signed [VEL_WIDTH-1:0] cmd_velocity,
    output logic [10:0]                 cycle_position,
    output logic signed [VEL_WIDTH-1:0] velocity,
    output logic                        at_speed,
    output logic                        moving
);

    import commutation_pkg::*;

    localparam int ACC_WIDTH  = 11 + FRAC_BITS;
    localparam int SUM_WIDTH  = ACC_WIDTH + 1;
    localparam int DIFF_WIDTH = VEL_WIDTH + 1;

    localparam logic [SUM_WIDTH-1:0] WRAP =
        SUM_WIDTH'(CYCLE_LENGTH * (2 ** FRAC_BITS));
    localparam logic signed [DIFF_WIDTH-1:0] STEP     = DIFF_WIDTH'(ACCEL_STEP);
    localparam logic signed [DIFF_WIDTH-1:0] NEG_STEP = -DIFF_WIDTH'(ACCEL_STEP);
    localparam logic signed [VEL_WIDTH-1:0]  VSTEP    = VEL_WIDTH'(ACCEL_STEP);

    logic                        tick;
    logic                        handshake;
    logic                        slew_active;
    logic                        entering_stop;
    logic [ACC_WIDTH-1:0]        phase_acc;
    logic [ACC_WIDTH-1:0]        phase_next;
    logic [SUM_WIDTH-1:0]        phase_sum;
    logic signed [VEL_WIDTH-1:0] target;
    logic signed [VEL_WIDTH-1:0] velocity_next;
    logic signed [DIFF_WIDTH-1:0] diff;
    state_t                      state;
    state_t                      state_next;

    update_tick_generator #(
        .DIVIDER(TICK_DIVIDER)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign handshake     = cmd_valid && cmd_ready;
    assign entering_stop = tick && (state != STOPPING) && (state_next == STOPPING);

    // A resting motor only starts slewing once it has both permission and a goal.
    assign slew_active = (state != IDLE) || (enable && (target != '0));

    assign diff = $signed({target[VEL_WIDTH-1], target})
                - $signed({velocity[VEL_WIDTH-1], velocity});

    always_comb begin
        velocity_next = velocity;
        if (slew_active) begin
            if (diff > STEP) begin
                velocity_next = velocity + VSTEP;
            end else if (diff < NEG_STEP) begin
                velocity_next = velocity - VSTEP;
            end else begin
                velocity_next = target;
            end
        end
    end

    // Sum is one bit wider than the accumulator so its MSB flags an underflow.
    assign phase_sum = {1'b0, phase_acc}
                     + {{(SUM_WIDTH - VEL_WIDTH){velocity[VEL_WIDTH-1]}}, velocity};

    always_comb begin
        phase_next = phase_acc;
        if (state != IDLE) begin
            if (phase_sum[SUM_WIDTH-1]) begin
                phase_next = ACC_WIDTH'(phase_sum + WRAP);
            end else if (phase_sum >= WRAP) begin
                phase_next = ACC_WIDTH'(phase_sum - WRAP);
            end else begin
                phase_next = phase_sum[ACC_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable && (target != '0)) begin
                    state_next = RAMP;
                end
            end
            RAMP: begin
                if (!enable) begin
                    state_next = STOPPING;
                end else if (velocity_next == target) begin
                    state_next = CRUISE;
                end
            end
            CRUISE: begin
                if (!enable) begin
                    state_next = STOPPING;
                end else if (target != velocity_next) begin
                    state_next = RAMP;
                end
            end
            STOPPING: begin
                if (velocity_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_acc <= '0;
            velocity  <= '0;
            state     <= IDLE;
        end else if (tick) begin
            phase_acc <= phase_next;
            velocity  <= velocity_next;
            state     <= state_next;
        end
    end

    // Stopping wins over a command arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target <= '0;
        end else if (entering_stop) begin
            target <= '0;
        end else if (handshake) begin
            target <= cmd_velocity;
        end
    end

    assign cycle_position = phase_acc[ACC_WIDTH-1:FRAC_BITS];
    assign cmd_ready      = accepts_command(state);
    assign at_speed       = (state == CRUISE);
    assign moving         = (velocity != '0);

endmodule

// File: doc/commutation_angle_generator.md
# commutation_angle_generator

Generates the electrical cycle position (0..1169) that drives the BLDC motor commutation stage. The block integrates a commanded signed velocity into an 11-bit cycle position at a fixed update rate. The velocity is slew-limited toward its target, so phase advance stays smooth on start, stop and direction reversal. It sits directly upstream of the commutation block, with `cycle_position` wired straight to its `cycle_position` input.

## Interface
- `CYCLE_LENGTH`, 1170: positions per electrical cycle; wrap modulus.
- `TICK_DIVIDER`, 1024: clk cycles per update tick (one 10-bit PWM period).
- `VEL_WIDTH`, 16: signed velocity width, two's complement.
- `FRAC_BITS`, 8: fractional bits of velocity and accumulator; velocity is Q7.8 positions/tick.
- `ACCEL_STEP`, 16: maximum velocity change per tick, same units; must be >0.

- `clk`: in, 1. Single clock.
- `reset`: in, 1. Asynchronous, active-high.
- `enable`: in, 1. Run request; low means ramp to zero, then idle.
- `cmd_valid`: in, 1. Target velocity offered.
- `cmd_ready`: out, 1. Target accepted when `cmd_valid && cmd_ready`.
- `cmd_velocity`: in, VEL_WIDTH. Signed target velocity.
- `cycle_position`: out, 11. Integer part of the phase accumulator, 0..CYCLE_LENGTH-1.
- `velocity`: out, VEL_WIDTH. Current slewed velocity.
- `at_speed`: out, 1. High in CRUISE.
- `moving`: out, 1. `velocity != 0`.

## Operation
- **Tick counter:** counts 0..TICK_DIVIDER-1 and wraps. `tick` is the cycle where count == TICK_DIVIDER-1. All velocity, phase and state updates happen only on tick cycles.
- **Target register:** loaded on handshake on any cycle. It is cleared to 0 on entry to STOPPING.
- **`cmd_ready`:** decoded from state. It is 1 in IDLE, RAMP and CRUISE, and 0 in STOPPING.
- **Slew:** on tick, `diff = target - velocity`. If |diff| ≤ ACCEL_STEP, velocity ← target; otherwise velocity moves ACCEL_STEP toward target. Compute diff at VEL_WIDTH+1 bits; no overflow is permitted.
- **Phase:** accumulator width is 11+FRAC_BITS, unsigned, range [0, CYCLE_LENGTH<<FRAC_BITS). On tick it adds the pre-update (registered) velocity, sign-extended, computed at 11+FRAC_BITS+1 bits.
  - If the sum is ≥ CYCLE_LENGTH<<FRAC_BITS, subtract CYCLE_LENGTH<<FRAC_BITS.
  - If the sum is negative, add CYCLE_LENGTH<<FRAC_BITS.
  - One correction always suffices because |velocity| < 128 < CYCLE_LENGTH.
- **State machine** (`state_t`: IDLE, RAMP, CRUISE, STOPPING), evaluated on tick after the slew:
  - **IDLE:** velocity is 0 and the phase is held. If `enable` and target≠0, go to RAMP.
  - **RAMP:** if `!enable`, go to STOPPING. Else if the new velocity == target, go to CRUISE.
  - **CRUISE:** if `!enable`, go to STOPPING. Else if target ≠ velocity (new command accepted), go to RAMP.
  - **STOPPING:** target is forced to 0. When the new velocity == 0, go to IDLE. `enable` is ignored until IDLE is reached.
- **Reversal:** the slew passes through 0 while the state stays RAMP. The phase decrements and wraps 0 → 1169 correctly.
- **Zero target while enabled:** the state moves RAMP → CRUISE at velocity 0. It does not go to IDLE.

## Timing
- **Reset values:** tick count 0, accumulator 0, velocity 0, target 0, state IDLE.
  - Outputs during reset: `cycle_position`=0, `velocity`=0, `at_speed`=0, `moving`=0, `cmd_ready`=1.
- **Output registers:** `cycle_position`, `velocity` and state are registered and change on the clk edge ending the tick cycle. `at_speed`, `moving` and `cmd_ready` decode the registered values.
- **Command/tick collision:** a handshake on the same cycle as tick takes effect at the next tick, because the current tick uses the old target.
- **Disable/tick collision:** `enable` falling on a tick cycle is acted on in that tick's transition.
- **Reset mid-operation:** all state clears immediately, asynchronously. The position does not resume from its prior value.
- **Throughput:** latency from a new target to its first velocity change is ≤ TICK_DIVIDER cycles. One command is accepted per cycle; a later command before the next tick overwrites the earlier one.

## Structure
- **Package `commutation_pkg`:** holds `CYCLE_LENGTH` (1170), the `state_t` enum, and a velocity typedef `velocity_t` (logic signed [VEL_WIDTH-1:0]). The commutation block shares `CYCLE_LENGTH` from this package.
- **Sub-module `update_tick_generator`:** a parameterized divider emitting a one-cycle `tick`.

## Test plan
All scenarios use TICK_DIVIDER=4 and ACCEL_STEP=16.
- **Start from rest:** reset, then `enable`=1 and cmd 0x0100 (1.0/tick).
  - Velocity steps 16, 32, … 256 over 16 ticks, then `at_speed`=1.
  - `cycle_position` increments by 1 per tick thereafter.
- **Forward wrap:** in CRUISE at 0x0200 with position 1168.
  - The next two ticks give 0, then 2.
- **Reverse wrap:** cmd 0xFF00 (-1.0) from 0x0100.
  - Velocity crosses 0 after 16 ticks and reaches -256 after 32.
  - Position decrements through 0 → 1169 → 1168.
- **Stop:** `enable`=0 during CRUISE at 0x0100.
  - STOPPING is entered with `cmd_ready`=0, and a cmd_valid offered then is not accepted.
  - Velocity reaches 0 in 16 ticks, then IDLE; the position freezes.
- **Collision:** cmd 0x0080 offered exactly on a tick cycle.
  - The velocity change first appears at the following tick.
- **Async reset mid-RAMP:** assert reset between clk edges.
  - Outputs go to 0 (`cmd_ready`=1) immediately, without waiting for a clock edge.
